// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, operand mode and saturation bounds for the pe_mac PE
package pe_pkg;

  localparam int PE_DATA_W = 8;
  localparam int PE_WGT_W  = 8;
  localparam int PE_ACC_W  = 24;

  typedef enum logic {PE_UNSIGNED, PE_SIGNED} pe_mode_e;

  // Bounds are returned 64 bits wide; callers keep the low acc_w bits (acc_w <= 63).
  function automatic logic [63:0] sat_max(input int acc_w, input pe_mode_e mode);
    if (mode == PE_SIGNED) return (64'd1 << (acc_w - 1)) - 64'd1;
    return (64'd1 << acc_w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int acc_w, input pe_mode_e mode);
    if (mode == PE_SIGNED) return ~((64'd1 << (acc_w - 1)) - 64'd1);
    return '0;
  endfunction

endpackage

// File: rtl/pe_mul.sv
// rtl/pe_mul.sv - combinational signed/unsigned multiplier for pe_mac
module pe_mul
  import pe_pkg::*;
#(
  parameter int A_W = PE_WGT_W,
  parameter int B_W = PE_DATA_W
) (
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               signed_mode,
  output logic [A_W+B_W-1:0] product
);

  localparam int P_W = A_W + B_W;

  pe_mode_e         mode;
  logic             a_ext;
  logic             b_ext;
  logic [P_W-1:0]   a_x;
  logic [P_W-1:0]   b_x;

  assign mode  = pe_mode_e'(signed_mode);
  assign a_ext = (mode == PE_SIGNED) & a[A_W-1];
  assign b_ext = (mode == PE_SIGNED) & b[B_W-1];
  assign a_x   = {{B_W{a_ext}}, a};
  assign b_x   = {{A_W{b_ext}}, b};

  // Low P_W bits of the product of the extended operands are exact in both modes.
  assign product = a_x * b_x;

endmodule

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - double-buffered weight MAC PE; define PE_SAT_EN to clamp the sum instead of wrapping
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int WGT_W  = PE_WGT_W,
  parameter int ACC_W  = PE_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WGT_W-1:0]  w_in,
  input  logic              w_load_en,
  input  logic              w_swap,
  input  logic              signed_mode,
  input  logic              PE_en,
  input  logic              PE_stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ifmap,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] ifmap_out,
  output logic              out_valid,
  output logic [ACC_W-1:0]  psum_out
);

  localparam int P_W = DATA_W + WGT_W;

  logic [WGT_W-1:0] shadow;
  logic [WGT_W-1:0] active;
  logic [P_W-1:0]   prod;
  logic             prod_sign;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;

  pe_mul #(.A_W(WGT_W), .B_W(DATA_W)) u_mul (
    .a           (active),
    .b           (ifmap),
    .signed_mode (signed_mode),
    .product     (prod)
  );

  assign prod_sign = signed_mode & prod[P_W-1];
  assign prod_ext  = PE_en ? {{(ACC_W - P_W){prod_sign}}, prod} : '0;

`ifdef PE_SAT_EN
  localparam logic [63:0] S_MAX64 = sat_max(ACC_W, PE_SIGNED);
  localparam logic [63:0] S_MIN64 = sat_min(ACC_W, PE_SIGNED);
  localparam logic [63:0] U_MAX64 = sat_max(ACC_W, PE_UNSIGNED);
  localparam logic [ACC_W-1:0] S_MAX = S_MAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] S_MIN = S_MIN64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] U_MAX = U_MAX64[ACC_W-1:0];

  logic [ACC_W:0] sum_wide;

  assign sum_wide = {signed_mode & psum_in[ACC_W-1], psum_in}
                  + {signed_mode & prod_ext[ACC_W-1], prod_ext};

  // Signed overflow shows as disagreement between the guard bit and the ACC_W sign bit.
  always_comb begin
    sum = sum_wide[ACC_W-1:0];
    if (signed_mode) begin
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) sum = sum_wide[ACC_W] ? S_MIN : S_MAX;
    end else if (sum_wide[ACC_W]) begin
      sum = U_MAX;
    end
  end
`else
  assign sum = psum_in + prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= '0;
      active    <= '0;
      ifmap_out <= '0;
      psum_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (w_load_en) shadow <= w_in;
      if (w_swap)    active <= w_load_en ? w_in : shadow;
      if (!PE_stall) begin
        out_valid <= in_valid;
        ifmap_out <= ifmap;
        psum_out  <= sum;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac.sv
// tb/tb_pe_mac.sv - scoreboard bench for pe_mac; honours PE_SAT_EN for expected sums
module tb_pe_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  w_in;
  logic        w_load_en, w_swap, signed_mode, PE_en, PE_stall, in_valid;
  logic [7:0]  ifmap;
  logic [23:0] psum_in;
  logic [7:0]  ifmap_out;
  logic        out_valid;
  logic [23:0] psum_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0]  ifm;
    logic [23:0] ps;
    logic        v;
  } exp_t;
  exp_t sb[$];

  logic [7:0]  m_shadow = '0, m_active = '0, m_ifm = '0;
  logic [23:0] m_ps = '0;
  logic        m_v = 1'b0;

  pe_mac #(.DATA_W(8), .WGT_W(8), .ACC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .w_in(w_in), .w_load_en(w_load_en), .w_swap(w_swap),
    .signed_mode(signed_mode), .PE_en(PE_en), .PE_stall(PE_stall), .in_valid(in_valid),
    .ifmap(ifmap), .psum_in(psum_in), .ifmap_out(ifmap_out), .out_valid(out_valid),
    .psum_out(psum_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model_sum(input logic [23:0] ps, input logic [7:0] w,
                                            input logic [7:0] x, input bit sm, input bit en);
    longint p, a, s;
    logic [63:0] r;
    if (!en)     p = 0;
    else if (sm) p = longint'($signed(w)) * longint'($signed(x));
    else         p = longint'(w) * longint'(x);
    a = sm ? longint'($signed(ps)) : longint'(ps);
    s = a + p;
`ifdef PE_SAT_EN
    if (sm) begin
      if (s > 64'sd8388607)  s = 64'sd8388607;
      if (s < -64'sd8388608) s = -64'sd8388608;
    end else if (s > 64'sd16777215) begin
      s = 64'sd16777215;
    end
`endif
    r = s;
    return r[23:0];
  endfunction

  task automatic cyc(input bit rst, input bit ld, input bit sw, input bit sm, input bit en,
                     input bit st, input bit v, input logic [7:0] w, input logic [7:0] x,
                     input logic [23:0] ps);
    exp_t e, g;
    @(negedge clk);
    rst_n = ~rst; w_load_en = ld; w_swap = sw; signed_mode = sm; PE_en = en;
    PE_stall = st; in_valid = v; w_in = w; ifmap = x; psum_in = ps;
    if (rst) begin
      m_shadow = '0; m_active = '0; m_ifm = '0; m_ps = '0; m_v = 1'b0;
    end else begin
      if (!st) begin
        m_ps  = model_sum(ps, m_active, x, sm, en);
        m_ifm = x;
        m_v   = v;
      end
      if (ld && sw) begin
        m_active = w; m_shadow = w;
      end else if (ld) begin
        m_shadow = w;
      end else if (sw) begin
        m_active = m_shadow;
      end
    end
    e.ifm = m_ifm; e.ps = m_ps; e.v = m_v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("ifmap_out", {24'd0, ifmap_out}, {24'd0, g.ifm});
    check("psum_out",  {8'd0, psum_out},   {8'd0, g.ps});
    check("out_valid", {31'd0, out_valid}, {31'd0, g.v});
  endtask

  initial begin
    rst_n = 1'b0; w_load_en = 0; w_swap = 0; signed_mode = 0; PE_en = 1; PE_stall = 0;
    in_valid = 0; w_in = 0; ifmap = 0; psum_in = 0;

    // reset, then unsigned 3*5+10
    cyc(1, 0, 0, 0, 1, 0, 1, 8'h55, 8'h66, 24'h777);
    check("reset_psum_const", {8'd0, psum_out}, 32'd0);
    cyc(0, 1, 0, 0, 1, 0, 0, 8'd3, 8'd0, 24'd0);
    cyc(0, 0, 1, 0, 1, 0, 0, 8'd0, 8'd0, 24'd0);
    cyc(0, 0, 0, 0, 1, 0, 1, 8'd0, 8'd5, 24'd10);
    check("basic_25", {8'd0, psum_out}, 32'd25);

    // signed vs unsigned with weight 0xFE
    cyc(0, 1, 1, 0, 1, 0, 0, 8'hFE, 8'd0, 24'd0);
    cyc(0, 0, 0, 1, 1, 0, 1, 8'd0, 8'h03, 24'd0);
    check("signed_m6", {8'd0, psum_out}, 32'h00FFFFFA);
    cyc(0, 0, 0, 0, 1, 0, 1, 8'd0, 8'h03, 24'd0);
    check("unsigned_762", {8'd0, psum_out}, 32'd762);

    // double buffer
    cyc(0, 1, 1, 0, 1, 0, 0, 8'd4, 8'd0, 24'd0);
    cyc(0, 1, 0, 0, 1, 0, 1, 8'd7, 8'd1, 24'd0);
    cyc(0, 0, 1, 0, 1, 0, 1, 8'd0, 8'd1, 24'd0);
    cyc(0, 0, 0, 0, 1, 0, 1, 8'd0, 8'd1, 24'd0);
    check("swap_7", {8'd0, psum_out}, 32'd7);
    cyc(0, 1, 1, 0, 1, 0, 0, 8'd9, 8'd0, 24'd0);
    cyc(0, 0, 0, 0, 1, 0, 1, 8'd0, 8'd1, 24'd0);
    check("ldswap_9", {8'd0, psum_out}, 32'd9);

    // stall stream 1,2,3 then reset during stall
    cyc(0, 0, 0, 0, 1, 0, 1, 8'd0, 8'd1, 24'd0);
    cyc(0, 0, 0, 0, 1, 1, 1, 8'd0, 8'd2, 24'd0);
    check("stall_hold", {24'd0, ifmap_out}, 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 1, 8'd0, 8'd3, 24'd0);
    cyc(1, 1, 1, 0, 1, 1, 1, 8'd5, 8'd4, 24'd0);

    // saturation / wrap
    cyc(0, 1, 1, 1, 1, 0, 0, 8'h7F, 8'd0, 24'd0);
    cyc(0, 0, 0, 1, 1, 0, 1, 8'd0, 8'h7F, 24'h7FFFF0);
`ifdef PE_SAT_EN
    check("sat_clamp", {8'd0, psum_out}, 32'h007FFFFF);
`else
    check("sat_wrap", {8'd0, psum_out}, 32'h00803EF1);
`endif

    // bypass
    cyc(0, 0, 0, 1, 0, 0, 1, 8'd0, 8'h55, 24'd1234);
    check("bypass", {8'd0, psum_out}, 32'd1234);

    for (int i = 0; i < 40; i++) begin
      cyc(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_mac.md
# pe_mac

Parametrised processing element for the CONV_unit systolic array, and the successor to the basic 8-bit multiply PE. It holds a double-buffered (shadow/active) weight and multiplies it with the incoming ifmap in signed or unsigned mode. It adds the product to an incoming partial sum and registers the result. It forwards the ifmap to the next PE, with valid qualification and stall freeze.

## Interface
Parameters:
- DATA_W, 8, ifmap width
- WGT_W, 8, weight width
- ACC_W, 24, partial-sum width; must be ≥ DATA_W+WGT_W+1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- w_in  in  WGT_W  weight data
- w_load_en  in  1  write w_in into shadow weight
- w_swap  in  1  copy shadow weight into active weight
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
- PE_en  in  1  1 = multiply, 0 = bypass (product forced to 0)
- PE_stall  in  1  freeze datapath registers
- in_valid  in  1  qualifies ifmap and psum_in
- ifmap  in  DATA_W  activation input
- psum_in  in  ACC_W  partial sum from upstream PE
- ifmap_out  out  DATA_W  registered ifmap to downstream PE
- out_valid  out  1  qualifies ifmap_out and psum_out
- psum_out  out  ACC_W  registered partial sum

## Operation
- Weights, with each rule evaluated independently every cycle, stall or not:
  - w_load_en=1: shadow <= w_in.
  - w_swap=1: active <= shadow.
  - Both asserted in the same cycle: active <= w_in (bypass) and shadow <= w_in.
- Product:
  - signed_mode=1: active × ifmap, both sign-extended, result DATA_W+WGT_W signed, sign-extended to ACC_W.
  - signed_mode=0: zero-extended.
  - PE_en=0: product = 0, so psum_out = psum_in (bypass).
- Sum: psum_in + extended product, computed in ACC_W+1 bits. Truncation or clamping is set by the configuration macro.
- Datapath registers (ifmap_out, psum_out, out_valid):
  - PE_stall=1: all three hold their value. This differs from the old PE, which zeroed its forwarded ifmap.
  - PE_stall=0: out_valid <= in_valid; ifmap_out <= ifmap; psum_out <= sum.
  - in_valid=0: out_valid <= 0, and ifmap_out/psum_out still load.
- Reset (rst_n=0 at an edge): shadow, active, ifmap_out, psum_out and out_valid all go to 0. Reset overrides stall, load and swap. Reset mid-stream discards in-flight data.

## Timing
- Latency 1 cycle: in_valid at edge N produces out_valid after edge N, provided PE_stall=0 at edge N.
- Stall at edge N: outputs after N equal outputs before N, and the inputs presented at N are lost. The upstream PE must hold them; no internal buffering.
- A swap at edge N affects the product computed for inputs sampled at edge N+1 onward.
- The product path is combinational within one cycle; no internal multiplier pipeline.

## Configuration
- PE_SAT_EN defined: the sum is clamped.
  - signed_mode=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - signed_mode=0: clamp to [0, 2^ACC_W-1].
- PE_SAT_EN undefined: the sum wraps modulo 2^ACC_W.

## Structure
- Shared package pe_pkg holds:
  - default DATA_W/WGT_W/ACC_W localparams;
  - typedef enum logic {PE_UNSIGNED, PE_SIGNED} pe_mode_e;
  - the saturation bound helper functions.
- One sub-module, pe_mul: combinational signed/unsigned multiplier (inputs a, b, signed_mode; output DATA_W+WGT_W). Instantiated once.

## Test plan
- Reset then idle: after rst_n low for one edge, all outputs are 0. With signed_mode=0, load w_in=3, swap, ifmap=5, psum_in=10, valid: next cycle psum_out=25, ifmap_out=5, out_valid=1.
- Signed: active weight 0xFE (-2), ifmap 0x03, psum_in=0, signed_mode=1 -> psum_out=-6 (0xFFFFFA at ACC_W=24). Same operands with signed_mode=0 -> 762.
- Double buffer: active=4; load shadow=7 without swap, ifmap=1 -> 4. Swap next cycle, ifmap=1 -> 7. Load+swap together with w_in=9 -> 9 on the following op.
- Stall: stream ifmap 1,2,3 with PE_stall high during the second -> ifmap_out sequence 1,1,3 and out_valid held high. Assert rst_n low during stall -> all outputs 0.
- Saturation: ACC_W=24, signed, psum_in=0x7FFFF0, product 127×127 -> with PE_SAT_EN 0x7FFFFF; without PE_SAT_EN wrap to 0x803EF1.
- Bypass: PE_en=0, psum_in=1234 -> psum_out=1234 regardless of weight and ifmap.
